mmap_timeout_guard: RTL
=======================

# mmap_timeout_guard

Bus-guard stage placed directly upstream of the APB peripheral wrapper's memory-mapped port, between the core's peripheral-region request and the mem-to-APB bridge. It registers each request and forwards it downstream. It then returns the downstream response to the core. If no `ready` arrives within a programmable cycle budget, it aborts the transaction, returns a fixed error word, and logs the fault. A hung or unmapped APB slave therefore can never stall the CPU indefinitely.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 256: maximum downstream wait in cycles; legal range 2..65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: read data returned on an aborted transaction.

Ports (name, direction, width, meaning):
- `clk_i` in 1: the single clock; all logic is on the rising edge.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `up_valid_i` in 1: request from the core; held until `up_ready_o`.
- `up_addr_i` in 32: request address.
- `up_wdata_i` in 32: write data.
- `up_wstrb_i` in 4: byte strobes; 0 means read.
- `up_rdata_o` out 32: response data.
- `up_ready_o` out 1: one-cycle completion pulse.
- `mmap_valid_o` out 1: forwarded request valid, toward the APB wrapper.
- `mmap_addr_o` out 32, `mmap_wdata_o` out 32, `mmap_wstrb_o` out 4: registered copies of the request.
- `mmap_rdata_i` in 32: downstream read data.
- `mmap_ready_i` in 1: downstream completion.
- `err_irq_o` out 1: sticky timeout flag.
- `err_addr_o` out 32: address of the most recent timed-out request.
- `err_cnt_o` out 8: timeout count, saturating at 255.
- `err_clr_i` in 1: clears `err_irq_o` and `err_cnt_o`.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE: `mmap_valid_o`=0 and `up_ready_o`=0. When `up_valid_i`=1:
  - latch addr, wdata and wstrb into the `mmap_*_o` registers;
  - clear the wait counter;
  - go to REQ.
- REQ: `mmap_valid_o`=1 and the `mmap_*_o` fields are stable.
  - If `mmap_ready_i`=1: latch `mmap_rdata_i` into `up_rdata_o` and go to RESP.
  - Else, if the counter equals TIMEOUT_CYCLES-1: abort. Load `ERR_RDATA` into `up_rdata_o`, set `err_irq_o`, load `err_addr_o` from `mmap_addr_o`, increment `err_cnt_o` (saturating), and go to RESP.
  - Else: increment the counter.
- RESP: `up_ready_o`=1 for exactly one cycle and `mmap_valid_o`=0. Go to IDLE.
- Upstream protocol:
  - The core must deassert `up_valid_i` in the cycle after `up_ready_o`.
  - The guard never launches a request from RESP.
- Counter width is 16 bits. The counter never wraps, because the abort fires at TIMEOUT_CYCLES-1.
- On an aborted write, the write is dropped: `mmap_valid_o` falls and the response data is still `ERR_RDATA`.
- `up_rdata_o` holds its last value outside RESP.
- Simultaneous events:
  - `mmap_ready_i` in the final budget cycle counts as normal completion, not a timeout.
  - A timeout and `err_clr_i` in the same cycle leave `err_irq_o`=1 and `err_cnt_o`=1. Set wins; the count restarts from 0 and then increments.
  - A `mmap_ready_i` pulse seen in IDLE or RESP is ignored.

## Timing
- Reset (`rst_n_i`=0 at an edge): FSM goes to IDLE. All outputs go to 0, including `up_rdata_o`, `err_addr_o` and `err_cnt_o`.
- Reset asserted mid-REQ: `mmap_valid_o` is 0 after that same edge, and no `up_ready_o` is issued.
- Latency, with request accepted at edge 0:
  - `mmap_valid_o` is high from cycle 1.
  - If `mmap_ready_i` arrives in cycle k (k≥1), `up_ready_o` is high in cycle k+1.
  - The guard adds 2 cycles per transaction.
- Timeout case: `mmap_valid_o` is high for exactly TIMEOUT_CYCLES cycles (cycles 1..TIMEOUT_CYCLES). `up_ready_o` is high in cycle TIMEOUT_CYCLES+1.
- Back-to-back: the next request can be accepted in the IDLE cycle right after RESP. Peak throughput is one transaction every 3 cycles plus the downstream wait.
- `err_clr_i` takes effect at the next edge.

## Test plan
- Read, downstream `ready` 3 cycles after `mmap_valid_o`, rdata 0x1234_5678 → `up_ready_o` 1 cycle later with rdata 0x1234_5678; `err_irq_o`=0.
- Write 0xA5A5_A5A5, wstrb 4'hF, to 0x0300_2000 → `mmap_addr_o`, `mmap_wdata_o` and `mmap_wstrb_o` match and stay stable until `ready`. Exactly one `up_ready_o` pulse.
- TIMEOUT_CYCLES=8, read of 0x0300_7000 that never gets `ready` → `mmap_valid_o` high for 8 cycles, then `up_ready_o` with 0xDEAD_BEEF. `err_irq_o`=1, `err_addr_o`=0x0300_7000, `err_cnt_o`=1.
- TIMEOUT_CYCLES=8, `ready` in the 8th valid cycle → normal data returned and no error logged. Then 300 consecutive timeouts → `err_cnt_o` saturates at 255.
- Timeout coincident with `err_clr_i` → `err_irq_o`=1 and `err_cnt_o`=1. `err_clr_i` alone → both 0.
- `rst_n_i` pulsed low in the 4th REQ cycle → `mmap_valid_o`=0 at the next edge, all outputs 0, no `up_ready_o`. The next request completes normally.

Source files
------------

// File: rtl/mmap_timeout_guard.sv
// rtl/mmap_timeout_guard.sv - bus guard that aborts hung memory-mapped transactions after a cycle budget
module mmap_timeout_guard #(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        up_valid_i,
  input  logic [31:0] up_addr_i,
  input  logic [31:0] up_wdata_i,
  input  logic [3:0]  up_wstrb_i,
  output logic [31:0] up_rdata_o,
  output logic        up_ready_o,
  output logic        mmap_valid_o,
  output logic [31:0] mmap_addr_o,
  output logic [31:0] mmap_wdata_o,
  output logic [3:0]  mmap_wstrb_o,
  input  logic [31:0] mmap_rdata_i,
  input  logic        mmap_ready_i,
  output logic        err_irq_o,
  output logic [31:0] err_addr_o,
  output logic [7:0]  err_cnt_o,
  input  logic        err_clr_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Abort fires on the last budget cycle, so the 16-bit counter never wraps.
  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [15:0] wait_cnt;
  logic        timeout;

  assign mmap_valid_o = (state == REQ);
  assign up_ready_o   = (state == RESP);

  // A ready in the final budget cycle wins over the abort.
  assign timeout = (state == REQ) && !mmap_ready_i && (wait_cnt == LAST_CNT);

  // Request capture, wait counting and response selection.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      wait_cnt     <= 16'd0;
      mmap_addr_o  <= 32'd0;
      mmap_wdata_o <= 32'd0;
      mmap_wstrb_o <= 4'd0;
      up_rdata_o   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (up_valid_i) begin
            mmap_addr_o  <= up_addr_i;
            mmap_wdata_o <= up_wdata_i;
            mmap_wstrb_o <= up_wstrb_i;
            wait_cnt     <= 16'd0;
            state        <= REQ;
          end
        end
        REQ: begin
          if (mmap_ready_i) begin
            up_rdata_o <= mmap_rdata_i;
            state      <= RESP;
          end else if (timeout) begin
            up_rdata_o <= ERR_RDATA;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Fault log: a timeout sets the flag even when a clear arrives in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_irq_o  <= 1'b0;
      err_addr_o <= 32'd0;
      err_cnt_o  <= 8'd0;
    end else if (timeout) begin
      err_irq_o  <= 1'b1;
      err_addr_o <= mmap_addr_o;
      if (err_clr_i)
        err_cnt_o <= 8'd1;
      else if (err_cnt_o != 8'hFF)
        err_cnt_o <= err_cnt_o + 8'd1;
    end else if (err_clr_i) begin
      err_irq_o <= 1'b0;
      err_cnt_o <= 8'd0;
    end
  end

endmodule
